mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arb_timer.sv | 36 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the I/D memory arbiter
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int DEF_TIMEOUT    = 31;
   localparam int DEF_STARVE_MAX = 3;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//------------------------------------------------------------------------------
// mem_arbiter_if : I-side, D-side, memory and status signals of the arbiter
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if;

   logic        i_req;
   logic [15:0] i_addr;
   logic        i_done;
   logic        i_err;
   logic [15:0] i_rdata;

   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_done;
   logic        d_err;
   logic [15:0] d_rdata;

   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_stall;
   logic        mem_done;
   logic [15:0] mem_rdata;

   logic        busy;
   logic        owner;

   // slave: the arbiter; master: the caches plus memory around it
   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
             mem_stall, mem_done, mem_rdata,
      output i_done, i_err, i_rdata, d_done, d_err, d_rdata,
             mem_en, mem_wr, mem_addr, mem_wdata, busy, owner
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
             mem_stall, mem_done, mem_rdata,
      input  i_done, i_err, i_rdata, d_done, d_err, d_rdata,
             mem_en, mem_wr, mem_addr, mem_wdata, busy, owner
   );

endinterface

`default_nettype wire

// File: rtl/mem_arb_timer.sv
//------------------------------------------------------------------------------
// mem_arb_timer : WAIT-state timeout counter, tc marks the TIMEOUT-th cycle
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tc
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + CW'(1);
      end
   end

   // Count starts at 0 on the first enabled cycle, so TIMEOUT-1 is the last one
   assign tc = (r_count == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter : single-outstanding arbiter of I/D cache requests onto memory
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   state_t        r_state;
   state_t        w_next;
   logic          r_owner;
   logic          r_wr;
   logic          r_err;
   logic [15:0]   r_addr;
   logic [15:0]   r_wdata;
   logic [15:0]   r_i_rdata;
   logic [15:0]   r_d_rdata;
   logic [SW-1:0] r_starve;
   logic          w_grant;
   logic          w_grant_d;
   logic          w_starved;
   logic          w_tc;
   logic          w_in_wait;
   logic          w_timer_clr;
   logic          w_resp;

   assign w_in_wait   = (r_state == ST_WAIT);
   assign w_timer_clr = !w_in_wait;
   assign w_resp      = (r_state == ST_RESP);
   assign w_starved   = (r_starve == SW'(STARVE_MAX));

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (w_timer_clr),
      .en    (w_in_wait),
      .tc    (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               w_grant   = 1'b1;
               // D has priority unless I has been passed over STARVE_MAX times
               w_grant_d = bus.d_req && !(bus.i_req && w_starved);
               w_next    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!bus.mem_stall) begin
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mem_done || w_tc) begin
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner   <= OWN_I;
         r_wr      <= 1'b0;
         r_err     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_starve  <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_grant_d ? OWN_D : OWN_I;
            r_err   <= 1'b0;
            if (w_grant_d) begin
               r_addr  <= bus.d_addr;
               r_wr    <= bus.d_wr;
               r_wdata <= bus.d_wdata;
            end else begin
               r_addr  <= bus.i_addr;
               r_wr    <= 1'b0;
               r_wdata <= '0;
            end
            if (w_grant_d && bus.i_req) begin
               if (!w_starved) begin
                  r_starve <= r_starve + SW'(1);
               end
            end else begin
               r_starve <= '0;
            end
         end
         // mem_done wins over a coinciding timeout
         if (w_in_wait) begin
            if (bus.mem_done) begin
               if (!r_wr) begin
                  if (r_owner == OWN_D) begin
                     r_d_rdata <= bus.mem_rdata;
                  end else begin
                     r_i_rdata <= bus.mem_rdata;
                  end
               end
            end else if (w_tc) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign bus.mem_en    = (r_state == ST_ISSUE);
   assign bus.mem_wr    = r_wr;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.owner     = r_owner;
   assign bus.i_done    = w_resp && (r_owner == OWN_I);
   assign bus.i_err     = w_resp && (r_owner == OWN_I) && r_err;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_done    = w_resp && (r_owner == OWN_D);
   assign bus.d_err     = w_resp && (r_owner == OWN_D) && r_err;
   assign bus.d_rdata   = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_arbiter : directed scenarios plus random traffic against a
//                  transaction-level model of the arbiter
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

   localparam int TO = 31;
   localparam int SM = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(
      .TIMEOUT    (TO),
      .STARVE_MAX (SM)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // memory responder knobs
   bit          rnd_mode   = 1'b0;
   int          done_pct   = 20;
   int          stall_len  = 0;
   int          done_delay = 1;
   logic [15:0] mem_val    = 16'hBEEF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expire(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Memory: directed mode stalls stall_len cycles then answers done_delay
   // cycles after acceptance (0 = never); random mode is free-running noise.
   initial begin : p_mem
      int  stall_left;
      int  cd;
      bit  seen;
      stall_left = 0;
      cd = 0;
      seen = 1'b0;
      bus.mem_stall = 1'b0;
      bus.mem_done  = 1'b0;
      bus.mem_rdata = 16'h0;
      forever begin
         @(negedge clk);
         if (rnd_mode) begin
            bus.mem_stall = ($urandom_range(0, 99) < 30);
            bus.mem_done  = ($urandom_range(0, 99) < done_pct);
            bus.mem_rdata = 16'($urandom);
         end else begin
            bus.mem_stall = 1'b0;
            bus.mem_done  = 1'b0;
            if (bus.mem_en) begin
               if (!seen) begin
                  seen = 1'b1;
                  stall_left = stall_len;
               end
               if (stall_left > 0) begin
                  bus.mem_stall = 1'b1;
                  stall_left--;
               end else begin
                  cd = done_delay;
               end
            end else begin
               seen = 1'b0;
               if (cd > 0) begin
                  cd--;
                  if (cd == 0) begin
                     bus.mem_done  = 1'b1;
                     bus.mem_rdata = mem_val;
                  end
               end
            end
         end
      end
   end

   // Transaction-level reference: phase 0 idle, 1 issuing, 2 waiting, 3 responding
   int          m_phase = 0;
   int          m_waited = 0;
   bit          m_own = 1'b0;
   bit          m_wr = 1'b0;
   bit          m_err = 1'b0;
   logic [15:0] m_addr = 16'h0;
   logic [15:0] m_wdata = 16'h0;
   logic [15:0] e_i_rdata = 16'h0;
   logic [15:0] e_d_rdata = 16'h0;
   bit          hist[$];   // 1 = a grant that went to D while I was waiting

   function automatic bit i_starved();
      if (hist.size() < SM) return 1'b0;
      for (int k = hist.size() - SM; k < hist.size(); k++) begin
         if (!hist[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step();
      bit pick_d;
      if (rst) begin
         m_phase = 0;
         m_own = 1'b0;
         m_wr = 1'b0;
         m_err = 1'b0;
         m_addr = 16'h0;
         m_wdata = 16'h0;
         e_i_rdata = 16'h0;
         e_d_rdata = 16'h0;
         hist.delete();
      end else if (m_phase == 0) begin
         if (bus.i_req || bus.d_req) begin
            pick_d = bus.d_req && !(bus.i_req && i_starved());
            hist.push_back(pick_d && bus.i_req);
            if (hist.size() > SM) void'(hist.pop_front());
            m_own = pick_d;
            m_err = 1'b0;
            m_addr  = pick_d ? bus.d_addr : bus.i_addr;
            m_wr    = pick_d ? bus.d_wr : 1'b0;
            m_wdata = bus.d_wdata;
            m_waited = 0;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (!bus.mem_stall) m_phase = 2;
      end else if (m_phase == 2) begin
         if (bus.mem_done) begin
            if (!m_wr) begin
               if (m_own) e_d_rdata = bus.mem_rdata;
               else       e_i_rdata = bus.mem_rdata;
            end
            m_phase = 3;
         end else begin
            m_waited++;
            if (m_waited == TO) begin
               m_err = 1'b1;
               m_phase = 3;
            end
         end
      end else begin
         m_phase = 0;
      end
   endtask

   always @(posedge clk) begin : p_cmp
      logic [71:0] act;
      logic [71:0] exp;
      bit          e_busy;
      bit          e_en;
      model_step();
      #1;
      if (chk_on) begin
         e_busy = (m_phase != 0);
         e_en   = (m_phase == 1);
         act = {bus.busy, bus.mem_en, bus.i_done, bus.i_err, bus.d_done, bus.d_err,
                bus.busy ? bus.owner : 1'b0,
                bus.mem_en ? bus.mem_wr : 1'b0,
                bus.mem_en ? bus.mem_addr : 16'h0,
                (bus.mem_en && bus.mem_wr) ? bus.mem_wdata : 16'h0,
                bus.i_rdata, bus.d_rdata};
         exp = {e_busy, e_en,
                (m_phase == 3) && !m_own, (m_phase == 3) && !m_own && m_err,
                (m_phase == 3) && m_own,  (m_phase == 3) && m_own && m_err,
                e_busy ? m_own : 1'b0,
                e_en ? m_wr : 1'b0,
                e_en ? m_addr : 16'h0,
                (e_en && m_wr) ? m_wdata : 16'h0,
                e_i_rdata, e_d_rdata};
         total++;
         if (act !== exp) begin
            bad++;
            $display("FAIL cycle_cmp: got %h expected %h at %0t", act, exp, $time);
         end
      end
   end

   task automatic wait_issue(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.mem_en && n < 200);
      if (!bus.mem_en) expire(name);
   endtask

   task automatic wait_done(input string name, input bit side_d, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(side_d ? bus.d_done : bus.i_done) && n < 100);
      if (!(side_d ? bus.d_done : bus.i_done)) expire(name);
   endtask

   initial begin : p_stim
      int n;
      int n1;
      bus.i_req = 1'b0;
      bus.i_addr = 16'h0;
      bus.d_req = 1'b0;
      bus.d_wr = 1'b0;
      bus.d_addr = 16'h0;
      bus.d_wdata = 16'h0;

      repeat (3) @(negedge clk);
      check("rst_status", {30'h0, bus.busy, bus.mem_en}, 32'h0);
      check("rst_done", {28'h0, bus.i_done, bus.i_err, bus.d_done, bus.d_err}, 32'h0);
      check("rst_owner", {31'h0, bus.owner}, 32'h0);
      check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 32'h0);
      rst = 1'b0;
      chk_on = 1'b1;

      // I-only fill, memory answers one cycle after acceptance
      bus.i_req = 1'b1;
      bus.i_addr = 16'h0040;
      wait_issue("i_only_issue");
      check("i_only_addr", {15'h0, bus.mem_wr, bus.mem_addr}, 32'h0000_0040);
      wait_done("i_only_done", 1'b0, n1);
      check("i_only_latency", 32'(1 + n1), 32'd3);
      check("i_only_rdata", {16'h0, bus.i_rdata}, 32'h0000_BEEF);
      check("i_only_d_done", {31'h0, bus.d_done}, 32'h0);
      bus.i_req = 1'b0;
      @(negedge clk);
      check("i_only_idle", {31'h0, bus.busy}, 32'h0);

      // simultaneous requests: D write first, then I
      mem_val = 16'h5A5A;
      bus.i_req = 1'b1;
      bus.i_addr = 16'h0200;
      bus.d_req = 1'b1;
      bus.d_wr = 1'b1;
      bus.d_addr = 16'h0100;
      bus.d_wdata = 16'h1234;
      wait_issue("both_d_issue");
      check("both_d_mem", {bus.owner, bus.mem_wr, 14'h0, bus.mem_wdata}, 32'hC000_1234);
      check("both_d_addr", {16'h0, bus.mem_addr}, 32'h0000_0100);
      wait_done("both_d_done", 1'b1, n);
      check("both_d_side", {30'h0, bus.i_done, bus.d_rdata == 16'h0}, 32'h1);
      bus.d_req = 1'b0;
      wait_issue("both_i_issue");
      check("both_i_mem", {bus.owner, bus.mem_wr, 14'h0, bus.mem_addr}, 32'h0000_0200);
      wait_done("both_i_done", 1'b0, n);
      check("both_i_rdata", {16'h0, bus.i_rdata}, 32'h0000_5A5A);
      bus.i_req = 1'b0;

      // D held continuously with I pending: grant pattern D,D,D,I repeating
      bus.i_req = 1'b1;
      bus.i_addr = 16'h0400;
      bus.d_req = 1'b1;
      bus.d_wr = 1'b0;
      bus.d_addr = 16'h0300;
      for (int g = 0; g < 8; g++) begin
         wait_issue("starve_issue");
         check($sformatf("starve_owner%0d", g), {31'h0, bus.owner}, (g % 4 == 3) ? 32'h0 : 32'h1);
         wait_done("starve_done", bus.owner, n);
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;

      // five stall cycles in ISSUE
      stall_len = 5;
      bus.i_req = 1'b1;
      bus.i_addr = 16'h0600;
      wait_issue("stall_issue");
      for (int k = 0; k < 6; k++) begin
         check($sformatf("stall_hold%0d", k), {bus.mem_en, 15'h0, bus.mem_addr}, 32'h8000_0600);
         @(negedge clk);
      end
      check("stall_wait", {30'h0, bus.busy, bus.mem_en}, 32'h2);
      wait_done("stall_done", 1'b0, n);
      bus.i_req = 1'b0;
      stall_len = 0;

      // memory never answers: timeout after TO wait cycles
      done_delay = 0;
      bus.i_req = 1'b1;
      bus.i_addr = 16'h0700;
      wait_issue("to_issue");
      wait_done("to_done", 1'b0, n);
      check("to_cycles", 32'(n), 32'd32);
      check("to_err", {30'h0, bus.i_err, bus.d_done}, 32'h2);
      bus.i_req = 1'b0;
      @(negedge clk);
      check("to_idle", {31'h0, bus.busy}, 32'h0);

      // reset in WAIT with a late mem_done
      done_delay = 3;
      bus.i_req = 1'b1;
      bus.i_addr = 16'h0800;
      wait_issue("rst_issue");
      @(negedge clk);
      check("rst_in_wait", {30'h0, bus.busy, bus.mem_en}, 32'h2);
      rst = 1'b1;
      bus.i_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort", {29'h0, bus.busy, bus.mem_en, bus.i_done}, 32'h0);
      repeat (2) begin
         @(negedge clk);
         check("rst_late", {29'h0, bus.busy, bus.i_done, bus.d_done}, 32'h0);
      end
      done_delay = 1;
      mem_val = 16'h7E57;
      bus.i_req = 1'b1;
      bus.i_addr = 16'h0900;
      wait_issue("post_rst_issue");
      check("post_rst_addr", {16'h0, bus.mem_addr}, 32'h0000_0900);
      wait_done("post_rst_done", 1'b0, n);
      check("post_rst_rdata", {15'h0, bus.i_err, bus.i_rdata}, 32'h0000_7E57);
      bus.i_req = 1'b0;
      @(negedge clk);

      // random traffic with occasional resets and timeout-heavy stretches
      rnd_mode = 1'b1;
      for (int blk = 0; blk < 12; blk++) begin
         case ($urandom_range(0, 2))
            0:       done_pct = 0;
            1:       done_pct = 15;
            default: done_pct = 50;
         endcase
         for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (!bus.i_req || bus.i_done || rst) begin
               bus.i_req  = ($urandom_range(0, 99) < 45);
               bus.i_addr = 16'($urandom);
            end
            if (!bus.d_req || bus.d_done || rst) begin
               bus.d_req   = ($urandom_range(0, 99) < 55);
               bus.d_wr    = 1'($urandom);
               bus.d_addr  = 16'($urandom);
               bus.d_wdata = 16'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
         end
      end
      @(negedge clk);
      rnd_mode = 1'b0;
      rst = 1'b0;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      repeat (40) @(negedge clk);
      check("final_idle", {31'h0, bus.busy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
